// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single-command SDRAM controller.
// One transaction is in flight at a time; requester fields are latched at grant.
module sdram_arbiter #(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    output logic                   p0_gnt,
    output logic                   p0_done,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    output logic                   p1_gnt,
    output logic                   p1_done,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_ready,
    input  logic                   busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t                 r_state;
    logic                   r_last;
    logic                   r_owner;
    logic                   r_we;
    logic                   r_p0_gnt, r_p1_gnt;
    logic                   r_p0_done, r_p1_done;
    logic                   r_rd_en, r_wr_en;
    logic [DATA_WIDTH-1:0]  r_rdata, r_wr_data;
    logic [HADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;

    logic                   w_pick1;
    logic                   w_we;
    logic [HADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]  w_wdata;

    // Port 1 wins if it is alone, or on a tie when port 0 was granted last.
    assign w_pick1 = p1_req & (~p0_req | ~r_last);
    assign w_we    = w_pick1 ? p1_we    : p0_we;
    assign w_addr  = w_pick1 ? p1_addr  : p0_addr;
    assign w_wdata = w_pick1 ? p1_wdata : p0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rdata   <= '0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        r_owner  <= w_pick1;
                        r_last   <= w_pick1;
                        r_we     <= w_we;
                        r_p0_gnt <= ~w_pick1;
                        r_p1_gnt <= w_pick1;
                        if (w_we) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr;
                            r_wr_data <= w_wdata;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_addr;
                        end
                        r_state <= ISSUE;
                    end
                end
                // Enable is held through controller init/refresh until busy shows acceptance.
                ISSUE: begin
                    if (busy) begin
                        r_rd_en <= 1'b0;
                        r_wr_en <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_we) begin
                        if (!busy) begin
                            r_p0_done <= ~r_owner;
                            r_p1_done <= r_owner;
                            r_state   <= IDLE;
                        end
                    end else if (rd_ready) begin
                        r_rdata   <= rd_data;
                        r_p0_done <= ~r_owner;
                        r_p1_done <= r_owner;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!busy) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign p0_gnt    = r_p0_gnt;
    assign p1_gnt    = r_p1_gnt;
    assign p0_done   = r_p0_done;
    assign p1_done   = r_p1_done;
    assign rdata     = r_rdata;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_enable = r_wr_en;
    assign rd_addr   = r_rd_addr;
    assign rd_enable = r_rd_en;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: behavioural controller model plus an
// in-order scoreboard of expected completions (port, kind, read data).
module tb_sdram_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p1_gnt, p0_done, p1_done;
    logic [DW-1:0] rdata, wr_data;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_enable, rd_enable;
    logic [DW-1:0] rd_data = '0;
    logic          rd_ready = 1'b0;
    logic          busy = 1'b0;

    sdram_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done),
        .rdata(rdata), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises m_delay cycles after an enable is seen,
    // reads return m_rdata via a one-cycle rd_ready, then busy falls.
    int            m_delay = 3;
    logic [DW-1:0] m_rdata = '0;
    int            spur_cnt = 0;
    int            spur_seen;
    int            m_st, m_cnt;
    logic          m_rd;

    always @(negedge clk) begin
        if (rst) begin
            m_st <= 0; m_cnt <= 0; m_rd <= 1'b0;
            busy <= 1'b0; rd_ready <= 1'b0; rd_data <= '0;
            spur_seen <= spur_cnt;
        end else begin
            case (m_st)
                0: begin
                    if (spur_seen != spur_cnt) begin
                        spur_seen <= spur_cnt;
                        busy <= 1'b1; rd_ready <= 1'b1; m_st <= 3;
                    end else if (rd_enable || wr_enable) begin
                        if (m_cnt + 1 == m_delay) begin
                            busy <= 1'b1; m_rd <= rd_enable; m_cnt <= 0; m_st <= 1;
                        end else m_cnt <= m_cnt + 1;
                    end else m_cnt <= 0;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_rd && m_cnt == 1) begin rd_ready <= 1'b1; rd_data <= m_rdata; end
                    if (m_rd && m_cnt == 2) rd_ready <= 1'b0;
                    if (m_cnt == (m_rd ? 3 : 2)) begin busy <= 1'b0; m_st <= 0; m_cnt <= 0; end
                end
                default: begin busy <= 1'b0; rd_ready <= 1'b0; m_st <= 0; end
            endcase
        end
    end

    typedef struct packed { logic port; logic we; logic [DW-1:0] rdata; } exp_t;
    exp_t exp_q[$];
    logic gord[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    int   gnt0_n = 0, gnt1_n = 0, done0_n = 0, done1_n = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk); #1;
        cyc++;
        chk("rd_wr_exclusive", rd_enable & wr_enable, 0);
        if (p0_gnt) begin gnt0_n++; gord.push_back(1'b0); end
        if (p1_gnt) begin gnt1_n++; gord.push_back(1'b1); end
        if (p0_done || p1_done) begin
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_port", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
                if (!e.we) chk("done_rdata", rdata, e.rdata);
            end
            if (p0_done) done0_n++;
            if (p1_done) done1_n++;
        end
    endtask

    task automatic wait_done(input int n, input int bound, input string tag);
        int base = done0_n + done1_n;
        int k = 0;
        while (done0_n + done1_n < base + n && k < bound) begin tick(); k++; end
        chk(tag, done0_n + done1_n - base, n);
    endtask

    task automatic settle();
        int k = 0;
        while ((m_st != 0 || busy) && k < 100) begin tick(); k++; end
        repeat (2) tick();
        chk("settle", k < 100, 1);
    endtask

    initial begin
        int en_n, k, base, d0_first, g1_first;
        logic ok;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {p0_gnt, p1_gnt, p0_done, p1_done, rd_enable, wr_enable,
                              rdata, wr_addr, rd_addr, wr_data}, 0);
        rst = 1'b0;

        // Single read from port 0
        m_delay = 3; m_rdata = 16'hBEEF;
        p0_we = 1'b0; p0_addr = 24'h012345; p0_req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 1'b0, 16'hBEEF});
        tick();
        chk("t1_gnt", {p0_gnt, p1_gnt}, 2'b10);
        chk("t1_enables", {rd_enable, wr_enable}, 2'b10);
        chk("t1_rd_addr", rd_addr, 24'h012345);
        p0_req = 1'b0;
        en_n = 1; k = 0;
        while (!p0_done && k < 50) begin tick(); if (rd_enable) en_n++; k++; end
        chk("t1_done_seen", p0_done, 1);
        chk("t1_enable_cycles", en_n, 3);
        tick();
        chk("t1_done_one_cycle", p0_done, 0);
        settle();
        chk("t1_rdata_hold", rdata, 16'hBEEF);

        // Simultaneous requests from reset: p0 write, p1 read, alternation
        rst = 1'b1;
        tick();
        p0_we = 1'b1; p0_addr = 24'h0000A0; p0_wdata = 16'h1111;
        p1_we = 1'b0; p1_addr = 24'h0000B0; m_rdata = 16'hCAFE;
        p0_req = 1'b1; p1_req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 1'b1, 16'h0});
        exp_q.push_back(exp_t'{1'b1, 1'b0, 16'hCAFE});
        exp_q.push_back(exp_t'{1'b0, 1'b1, 16'h0});
        gord.delete();
        base = done0_n + done1_n;
        rst = 1'b0;
        d0_first = 0; g1_first = 0; k = 0;
        while (gord.size() < 3 && k < 300) begin
            tick(); k++;
            if (p0_done && d0_first == 0) d0_first = cyc;
            if (p1_gnt && g1_first == 0) g1_first = cyc;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("t2_grant_count", gord.size(), 3);
        if (gord.size() >= 3) chk("t2_grant_order", {gord[0], gord[1], gord[2]}, 3'b010);
        chk("t2_p1_after_p0_done", g1_first > d0_first, 1);
        wait_done(base + 3 - (done0_n + done1_n), 100, "t2_all_done");
        settle();

        // Refresh stall: controller takes 20 cycles to accept a p1 write
        m_delay = 20;
        p1_we = 1'b1; p1_addr = 24'h0ABCDE; p1_wdata = 16'h5A5A; p1_req = 1'b1;
        exp_q.push_back(exp_t'{1'b1, 1'b1, 16'h0});
        base = done1_n;
        tick();
        chk("t3_gnt", {p0_gnt, p1_gnt}, 2'b01);
        chk("t3_wr_enable", wr_enable, 1);
        p1_req = 1'b0;
        en_n = 1; ok = 1'b1; k = 0;
        while (!p1_done && k < 80) begin
            tick(); k++;
            if (wr_enable) begin
                en_n++;
                ok = ok & (wr_addr == 24'h0ABCDE) & (wr_data == 16'h5A5A);
            end
        end
        chk("t3_enable_cycles", en_n, 20);
        chk("t3_addr_data_stable", ok, 1);
        settle();
        chk("t3_single_done", done1_n - base, 1);

        // Spurious busy/rd_ready while idle
        base = gnt0_n + gnt1_n + done0_n + done1_n;
        spur_cnt++;
        ok = 1'b0;
        repeat (6) begin tick(); ok = ok | rd_enable | wr_enable; end
        chk("spur_no_activity", {ok, 8'(gnt0_n + gnt1_n + done0_n + done1_n - base)}, 0);

        // One-cycle p1 request; requester fields change after grant
        m_delay = 3; m_rdata = 16'h1234;
        p1_we = 1'b0; p1_addr = 24'h000777; p1_req = 1'b1;
        exp_q.push_back(exp_t'{1'b1, 1'b0, 16'h1234});
        base = gnt1_n;
        tick();
        chk("t4_gnt", {p0_gnt, p1_gnt}, 2'b01);
        p1_req = 1'b0; p1_we = 1'b1; p1_addr = 24'hFFFFFF; p1_wdata = 16'hDEAD;
        ok = 1'b1; k = 0;
        while (!p1_done && k < 50) begin
            tick(); k++;
            if (wr_enable) ok = 1'b0;
            if (rd_enable && rd_addr != 24'h000777) ok = 1'b0;
        end
        chk("t4_done_seen", p1_done, 1);
        chk("t4_latched_fields", ok, 1);
        settle();
        repeat (5) tick();
        chk("t4_single_grant", gnt1_n - base, 1);

        // Async reset while a p0 read waits for data
        m_rdata = 16'h7777;
        p0_we = 1'b0; p0_addr = 24'h000123; p0_req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 1'b0, 16'h7777});
        tick();
        chk("t5_gnt", p0_gnt, 1);
        p0_req = 1'b0;
        k = 0;
        while (rd_enable && k < 50) begin tick(); k++; end
        #2 rst = 1'b1;
        #1 chk("t5_async_clear", {p0_gnt, p1_gnt, p0_done, p1_done, rd_enable, wr_enable,
                                 rdata, wr_addr, rd_addr, wr_data}, 0);
        exp_q.delete();
        base = done0_n;
        repeat (3) tick();
        chk("t5_no_done", done0_n - base, 0);
        gnt0_n = 0; gnt1_n = 0; done0_n = 0; done1_n = 0;
        rst = 1'b0;
        p0_we = 1'b1; p0_addr = 24'h000011; p0_wdata = 16'hAAAA;
        p1_we = 1'b1; p1_addr = 24'h000022; p1_wdata = 16'hBBBB;
        p0_req = 1'b1; p1_req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 1'b1, 16'h0});
        exp_q.push_back(exp_t'{1'b1, 1'b1, 16'h0});
        tick();
        chk("t5_first_gnt_p0", {p0_gnt, p1_gnt}, 2'b10);
        p0_req = 1'b0;
        k = 0;
        while (!p1_gnt && k < 60) begin tick(); k++; end
        p1_req = 1'b0;
        chk("t5_p1_gnt", p1_gnt, 1);
        wait_done(2 - (done0_n + done1_n), 60, "t5_all_done");
        settle();

        // Quiescence bookkeeping
        chk("q_empty", exp_q.size(), 0);
        chk("p0_gnt_eq_done", gnt0_n, done0_n);
        chk("p1_gnt_eq_done", gnt1_n, done1_n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 24, meaning host address width (bank+row+col).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning host data width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, meaning reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports p0_req / p1_req, input, 1, meaning the requester wants a transaction.
REQ-006 SHALL have ports p0_we / p1_we, input, 1, meaning 1 = write, 0 = read.
REQ-007 SHALL have ports p0_addr / p1_addr, input, HADDR_WIDTH, meaning the host address.
REQ-008 SHALL have ports p0_wdata / p1_wdata, input, DATA_WIDTH, meaning the write data.
REQ-009 SHALL have ports p0_gnt / p1_gnt, output, 1, meaning a one-cycle pulse that the request is latched.
REQ-010 SHALL have ports p0_done / p1_done, output, 1, meaning a one-cycle pulse that the transaction completed.
REQ-011 SHALL have port rdata, output, DATA_WIDTH, meaning read data, valid while the px_done of a read is high.
REQ-012 SHALL have controller-side ports wr_addr, wr_data, wr_enable, rd_addr and rd_enable (outputs), plus rd_data, rd_ready and busy (inputs), widths matching the host interface.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN.
REQ-014 IDLE: if any px_req is high, SHALL select a port, latch its we/addr/wdata, pulse its px_gnt for one cycle, and go to ISSUE.
- If no request is pending, SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin with a last-granted pointer.
- If both ports request, the port not last granted wins.
- If only one port requests, it wins regardless of the pointer.
- The pointer updates on grant.
REQ-016 ISSUE: SHALL drive rd_enable (read) or wr_enable (write) high continuously, with the latched address on rd_addr/wr_addr and the latched data on wr_data.
- Stays in ISSUE until busy=1, then deasserts the enable and goes to WAIT.
- Holding the enable covers controller init and refresh, during which busy=0 and the command is not yet taken.
REQ-017 rd_enable and wr_enable SHALL never be high together.
- Both SHALL be low outside ISSUE.
REQ-018 WAIT, read: on rd_ready=1, SHALL register rd_data into rdata and pulse the owner's px_done the next cycle, then go to DRAIN.
REQ-019 WAIT, write: on busy=0, SHALL pulse the owner's px_done the next cycle and go to IDLE.
REQ-020 DRAIN: SHALL stay until busy=0, then go to IDLE.
- This guarantees the controller is idle before the next issue.
REQ-021 Exactly one px_done SHALL pulse per px_gnt, to the same port, in grant order.
REQ-022 rdata SHALL hold its last value between reads.
REQ-023 Requester inputs SHALL be ignored after px_gnt until return to IDLE; the latched copies are used.
- A requester may drop or change px_req the cycle after px_gnt.
REQ-024 Earliest re-grant SHALL be the cycle after the FSM enters IDLE; no back-to-back grant in the done cycle.
REQ-025 An rd_ready or busy edge arriving in a state where it is not expected SHALL be ignored with no state change.

Reset
REQ-026 On rst=1, immediately and asynchronously:
- state = IDLE;
- all px_gnt, px_done, rd_enable, wr_enable = 0;
- rdata, wr_addr, rd_addr, wr_data = 0;
- pointer = port 1 last granted (port 0 wins the first tie).
REQ-027 Reset mid-transaction SHALL abandon the transaction with no px_done.
- The controller's reset is not driven by this block.

Verification
REQ-028 Single read: p0_req=1, p0_we=0, p0_addr=24'h012345; model returns busy after 3 cycles, rd_ready with rd_data=16'hBEEF -> p0_gnt 1 pulse, rd_enable held until busy, p0_done with rdata=16'hBEEF, back to IDLE after busy=0.
REQ-029 Simultaneous requests: p0 write 16'h1111, p1 read, both asserted from reset -> p0 granted first; p1 granted only after p0_done and busy=0; p1 request repeated -> p0 granted next (alternation).
REQ-030 Refresh stall: the model holds busy=0 for 20 cycles after wr_enable rises -> wr_enable stays high all 20 cycles, wr_addr/wr_data stable, single p1_done after busy falls.
REQ-031 Request drop: p1_req held high 1 cycle only -> p1_gnt, and the transaction still completes with p1_done; no second grant.
REQ-032 Async reset asserted in WAIT during a read -> outputs zero within the same cycle, no p0_done, next request granted to port 0.
REQ-033 Assertions: never rd_enable&wr_enable; count(px_gnt)==count(px_done) per port at quiescence.
